// File: rtl/counter_nb.sv
// counter_nb: parametrised N-bit multi-mode counter.
// Up/down by 1 or by STEP within 0..LIMIT, parallel load, hold, and a
// cascade carry-in. SATURATE selects clamping instead of modulo wrap.
// Q, RCO and LOAD are all registered. RCO is high for the cycle after an
// edge on which the count crossed a bound.
module counter_nb #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CI,
  input  logic [2:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] STEP,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             LOAD
);

  localparam logic [2:0] MODE_UP        = 3'b000;
  localparam logic [2:0] MODE_DOWN      = 3'b001;
  localparam logic [2:0] MODE_UP_STEP   = 3'b010;
  localparam logic [2:0] MODE_DOWN_STEP = 3'b011;
  localparam logic [2:0] MODE_LOAD      = 3'b100;

  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] ZERO_X = '0;

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_q, load_d;

  // One extra bit keeps Q+k and LIMIT+1 free of overflow.
  logic [WIDTH:0] q_x, k_x, lim_x, range_x;
  logic [WIDTH:0] sum_x, sub_x, under_x, up_mod_x, dn_rem_x, dn_wrap_x;
  logic           is_count_mode, is_down;
  logic           unused_bits;

  assign is_count_mode = (MODO == MODE_UP) || (MODO == MODE_DOWN) ||
                         (MODO == MODE_UP_STEP) || (MODO == MODE_DOWN_STEP);
  assign is_down       = MODO[0];

  // Wide arithmetic: step select, sum, difference and modulo-R reductions.
  always_comb begin
    q_x      = {1'b0, q_q};
    lim_x    = {1'b0, LIMIT};
    range_x  = lim_x + ONE_X;
    k_x      = MODO[1] ? {1'b0, STEP} : ONE_X;
    sum_x    = q_x + k_x;
    sub_x    = q_x - k_x;
    // Only meaningful when Q < k: the distance below zero, folded into
    // 0..LIMIT by counting back from R.
    under_x  = k_x - q_x;
    up_mod_x = sum_x % range_x;
    dn_rem_x = under_x % range_x;
    if (dn_rem_x == ZERO_X) begin
      dn_wrap_x = ZERO_X;
    end else begin
      dn_wrap_x = range_x - dn_rem_x;
    end
  end

  // The wrapped results are always below R <= 2^WIDTH, so the top bit is zero.
  assign unused_bits = ^{up_mod_x[WIDTH], dn_wrap_x[WIDTH], sub_x[WIDTH]};

  // Next-state selection for count, flag and load strobe.
  always_comb begin
    q_d    = q_q;
    rco_d  = 1'b0;
    load_d = 1'b0;
    if (ENABLE) begin
      if (MODO == MODE_LOAD) begin
        q_d    = D;
        load_d = 1'b1;
      end else if (is_count_mode && CI && (k_x != ZERO_X)) begin
        if (!is_down) begin
          if (q_x > lim_x) begin
            // Out-of-range value (e.g. after a load) restarts the range.
            q_d   = '0;
            rco_d = 1'b1;
          end else if (sum_x > lim_x) begin
            rco_d = 1'b1;
            q_d   = SATURATE ? LIMIT : up_mod_x[WIDTH-1:0];
          end else begin
            q_d = sum_x[WIDTH-1:0];
          end
        end else begin
          if (q_x >= k_x) begin
            q_d = sub_x[WIDTH-1:0];
          end else begin
            rco_d = 1'b1;
            q_d   = SATURATE ? '0 : dn_wrap_x[WIDTH-1:0];
          end
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (RESET) begin
      q_q    <= '0;
      rco_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      load_q <= load_d;
    end
  end

  assign Q    = q_q;
  assign RCO  = rco_q;
  assign LOAD = load_q;

endmodule

// File: tb/tb_counter_nb.sv
// Bench for counter_nb: directed stimulus pushes expected results into a
// scoreboard queue; a monitor on the falling edge pops and compares.
module tb_counter_nb;

  localparam logic [2:0] UP = 3'b000, DN = 3'b001, UPS = 3'b010, DNS = 3'b011;
  localparam logic [2:0] LD = 3'b100, HLD = 3'b101, R6 = 3'b110, R7 = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the wrap and saturate instances
  logic       rst, en, ci;
  logic [2:0] modo;
  logic [3:0] d, step, limit;
  logic [3:0] q_m, q_s;
  logic       rco_m, load_m, rco_s, load_s;

  // cascade stimulus
  logic       c_rst, c_gate;
  logic [2:0] c_modo;
  logic [3:0] c_dlo, c_dhi;
  logic [3:0] q_lo, q_hi;
  logic       rco_lo, load_lo, rco_hi, load_hi, ci_hi;
  assign ci_hi = rco_lo & c_gate;

  counter_nb #(.WIDTH(4), .SATURATE(1'b0)) dut (
    .clk(clk), .RESET(rst), .ENABLE(en), .CI(ci), .MODO(modo), .D(d),
    .STEP(step), .LIMIT(limit), .Q(q_m), .RCO(rco_m), .LOAD(load_m));

  counter_nb #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .RESET(rst), .ENABLE(en), .CI(ci), .MODO(modo), .D(d),
    .STEP(step), .LIMIT(limit), .Q(q_s), .RCO(rco_s), .LOAD(load_s));

  counter_nb #(.WIDTH(4), .SATURATE(1'b0)) u_lo (
    .clk(clk), .RESET(c_rst), .ENABLE(1'b1), .CI(1'b1), .MODO(c_modo), .D(c_dlo),
    .STEP(4'd1), .LIMIT(4'hF), .Q(q_lo), .RCO(rco_lo), .LOAD(load_lo));

  counter_nb #(.WIDTH(4), .SATURATE(1'b0)) u_hi (
    .clk(clk), .RESET(c_rst), .ENABLE(1'b1), .CI(ci_hi), .MODO(c_modo), .D(c_dhi),
    .STEP(4'd1), .LIMIT(4'hF), .Q(q_hi), .RCO(rco_hi), .LOAD(load_hi));

  typedef struct {
    int          sel;   // 0 wrap instance, 1 saturate instance, 2 cascade
    logic [7:0]  eq;
    logic        er;
    logic        el;
    string       nm;
    int unsigned stamp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every entry whose sampling edge has already passed
  exp_t       e;
  logic [7:0] aq;
  logic       ar, al;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].stamp < cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0:       begin aq = {4'h0, q_m};  ar = rco_m;  al = load_m; end
        1:       begin aq = {4'h0, q_s};  ar = rco_s;  al = load_s; end
        default: begin aq = {q_hi, q_lo}; ar = rco_lo | rco_hi; al = load_lo & load_hi; end
      endcase
      checks++;
      if (aq !== e.eq || ar !== e.er || al !== e.el) begin
        errors++;
        $display("FAIL %s: got Q=%h RCO=%b LOAD=%b, want Q=%h RCO=%b LOAD=%b",
                 e.nm, aq, ar, al, e.eq, e.er, e.el);
      end else begin
        $display("ok   %s: Q=%h RCO=%b LOAD=%b", e.nm, aq, ar, al);
      end
    end
  end

  task automatic push(input int sel, input logic [7:0] eq, input logic er,
                      input logic el, input string nm);
    exp_t x;
    x.sel = sel; x.eq = eq; x.er = er; x.el = el; x.nm = nm; x.stamp = cyc;
    sb.push_back(x);
  endtask

  task automatic drv(input int sel, input logic r, input logic n, input logic c,
                     input logic [2:0] m, input logic [3:0] dv, input logic [3:0] st,
                     input logic [3:0] lim, input logic [3:0] eq, input logic er,
                     input logic el, input string nm);
    @(negedge clk);
    rst = r; en = n; ci = c; modo = m; d = dv; step = st; limit = lim;
    push(sel, {4'h0, eq}, er, el, nm);
  endtask

  task automatic cdrv(input logic r, input logic [2:0] m, input logic [3:0] dlo,
                      input logic [3:0] dhi, input logic g, input logic [7:0] eq,
                      input logic er, input logic el, input string nm);
    @(negedge clk);
    c_rst = r; c_modo = m; c_dlo = dlo; c_dhi = dhi; c_gate = g;
    push(2, eq, er, el, nm);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ci = 1'b1; modo = UP; d = '0; step = '0; limit = 4'hF;
    c_rst = 1'b1; c_gate = 1'b1; c_modo = UP; c_dlo = '0; c_dhi = '0;

    // reset and hold
    drv(0, 1, 1, 1, UP, 0, 0, 15, 0, 0, 0, "reset1");
    drv(0, 1, 1, 1, UP, 0, 0, 15, 0, 0, 0, "reset2");
    drv(0, 0, 1, 1, UP, 0, 0, 15, 1, 0, 0, "up1");
    drv(0, 0, 1, 1, UP, 0, 0, 15, 2, 0, 0, "up2");
    drv(0, 0, 1, 1, UP, 0, 0, 15, 3, 0, 0, "up3");
    drv(0, 0, 0, 1, UP, 0, 0, 15, 3, 0, 0, "en_lo1");
    drv(0, 0, 0, 1, UP, 0, 0, 15, 3, 0, 0, "en_lo2");
    drv(0, 1, 1, 1, LD, 7, 0, 15, 0, 0, 0, "rst_in_load");
    drv(0, 0, 1, 1, HLD, 7, 0, 15, 0, 0, 0, "hold_after_rst");

    // up wrap at LIMIT=15
    drv(0, 0, 1, 1, LD, 14, 0, 15, 14, 0, 1, "load14");
    drv(0, 0, 1, 1, UP, 0, 0, 15, 15, 0, 0, "wrap_15");
    drv(0, 0, 1, 1, UP, 0, 0, 15, 0, 1, 0, "wrap_0");
    drv(0, 0, 1, 1, UP, 0, 0, 15, 1, 0, 0, "wrap_1");

    // carry-in low, hold and reserved modes, load ignores CI
    drv(0, 0, 1, 0, UP, 0, 0, 15, 1, 0, 0, "ci_lo");
    drv(0, 0, 1, 1, HLD, 0, 0, 15, 1, 0, 0, "mode_hold");
    drv(0, 0, 1, 1, R6, 0, 0, 15, 1, 0, 0, "mode_110");
    drv(0, 0, 1, 1, R7, 0, 0, 15, 1, 0, 0, "mode_111");
    drv(0, 0, 1, 0, LD, 5, 0, 15, 5, 0, 1, "load_ci_lo");
    drv(0, 0, 1, 1, HLD, 5, 0, 15, 5, 0, 0, "load_pulse_end");

    // modulo step, LIMIT=9 (R=10)
    drv(0, 0, 1, 1, LD, 0, 4, 9, 0, 0, 1, "mod_load0");
    drv(0, 0, 1, 1, UPS, 0, 4, 9, 4, 0, 0, "ups4_a");
    drv(0, 0, 1, 1, UPS, 0, 4, 9, 8, 0, 0, "ups4_b");
    drv(0, 0, 1, 1, UPS, 0, 4, 9, 2, 1, 0, "ups4_wrap");
    drv(0, 0, 1, 1, UPS, 0, 4, 9, 6, 0, 0, "ups4_d");
    drv(0, 0, 1, 1, LD, 2, 3, 9, 2, 0, 1, "mod_load2");
    drv(0, 0, 1, 1, DNS, 0, 3, 9, 9, 1, 0, "dns3_wrap");
    drv(0, 0, 1, 1, DNS, 0, 3, 9, 6, 0, 0, "dns3_b");
    drv(0, 0, 1, 1, DNS, 0, 15, 9, 1, 1, 0, "dns15_wrap");
    drv(0, 0, 1, 1, LD, 2, 15, 2, 2, 0, 1, "lim2_load2");
    drv(0, 0, 1, 1, UPS, 0, 15, 2, 2, 1, 0, "ups15_multi_wrap");

    // LIMIT=0
    drv(0, 0, 1, 1, UP, 0, 0, 0, 0, 1, 0, "lim0_entry");
    drv(0, 0, 1, 1, UP, 0, 0, 0, 0, 1, 0, "lim0_up");
    drv(0, 0, 1, 1, DN, 0, 0, 0, 0, 1, 0, "lim0_down");

    // load out of range, then count
    drv(0, 0, 1, 1, LD, 14, 0, 9, 14, 0, 1, "load_oor");
    drv(0, 0, 1, 1, UP, 0, 0, 9, 0, 1, 0, "oor_up");
    drv(0, 0, 1, 1, UP, 0, 0, 9, 1, 0, 0, "oor_up2");
    drv(0, 0, 1, 1, DNS, 0, 0, 9, 1, 0, 0, "step0_hold");
    drv(0, 0, 1, 1, DN, 0, 0, 9, 0, 0, 0, "down_to0");
    drv(0, 0, 1, 1, DN, 0, 0, 9, 9, 1, 0, "down_wrap");

    // saturating instance, LIMIT=12
    drv(1, 0, 1, 1, LD, 10, 5, 12, 10, 0, 1, "sat_load10");
    drv(1, 0, 1, 1, UPS, 0, 5, 12, 12, 1, 0, "sat_up_a");
    drv(1, 0, 1, 1, UPS, 0, 5, 12, 12, 1, 0, "sat_up_b");
    drv(1, 0, 1, 1, UPS, 0, 5, 12, 12, 1, 0, "sat_up_c");
    drv(1, 0, 1, 1, LD, 11, 1, 12, 11, 0, 1, "sat_load11");
    drv(1, 0, 1, 1, UP, 0, 1, 12, 12, 0, 0, "sat_exact");
    drv(1, 0, 1, 1, UP, 0, 1, 12, 12, 1, 0, "sat_over");
    drv(1, 0, 1, 1, LD, 0, 1, 12, 0, 0, 1, "sat_load0");
    drv(1, 0, 1, 1, DN, 0, 1, 12, 0, 1, 0, "sat_dn_a");
    drv(1, 0, 1, 1, DN, 0, 1, 12, 0, 1, 0, "sat_dn_b");
    drv(1, 0, 1, 1, LD, 3, 5, 12, 3, 0, 1, "sat_load3");
    drv(1, 0, 1, 1, DNS, 0, 5, 12, 0, 1, 0, "sat_dns5");

    // cascade: {upper,lower}
    cdrv(1, UP, 0, 0, 1, 8'h00, 0, 0, "cas_reset");
    cdrv(0, LD, 4'hF, 4'h0, 1, 8'h0F, 0, 1, "cas_load0F");
    cdrv(0, UP, 0, 0, 1, 8'h00, 1, 0, "cas_lo_wrap");
    cdrv(0, UP, 0, 0, 1, 8'h11, 0, 0, "cas_hi_inc");
    cdrv(0, UP, 0, 0, 1, 8'h12, 0, 0, "cas_hi_hold");
    cdrv(0, LD, 4'hF, 4'h1, 1, 8'h1F, 0, 1, "cas_load1F");
    cdrv(0, UP, 0, 0, 0, 8'h10, 1, 0, "cas_wrap_ci_off");
    cdrv(0, UP, 0, 0, 0, 8'h11, 0, 0, "cas_hi_frozen");

    // drain, with a bound
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
